// File: rtl/eth_phy_10g_rx_block_lock_ctrl.sv
// 10GBASE-R receive block-lock sequencer: hunts for 66-bit alignment via SERDES
// bitslip, tracks lock quality per header window, and requests a SERDES reset when hunting stalls.
module eth_phy_10g_rx_block_lock_ctrl #(
  parameter int HDR_WIDTH            = 2,
  parameter int BITSLIP_HIGH_CYCLES  = 1,
  parameter int BITSLIP_LOW_CYCLES   = 8,
  parameter int LOCK_VALID_COUNT     = 64,
  parameter int UNLOCK_INVALID_COUNT = 16,
  parameter int MAX_SLIPS            = 66,
  parameter int RESET_HOLD_CYCLES    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 serdes_rx_reset_req,
  output logic                 rx_block_lock,
  output logic [6:0]           rx_slip_count
);

  localparam int SW = $clog2(LOCK_VALID_COUNT + 1);
  localparam int IW = $clog2(UNLOCK_INVALID_COUNT + 1);
  localparam int TW = 16;

  localparam logic [SW-1:0] SH_LAST   = SW'(LOCK_VALID_COUNT - 1);
  localparam logic [IW-1:0] INV_LAST  = IW'(UNLOCK_INVALID_COUNT - 1);
  localparam logic [6:0]    SLIP_LAST = 7'(MAX_SLIPS - 1);
  localparam bit            SLIP_CAPPED = (MAX_SLIPS <= 127);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(BITSLIP_LOW_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    HUNT       = 3'd0,
    SLIP       = 3'd1,
    SETTLE     = 3'd2,
    LOCKED     = 3'd3,
    RESET_HOLD = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] sh_cnt;
  logic [IW-1:0] inv_cnt;
  logic [6:0]    slip_cnt;
  logic [TW-1:0] timer;

  logic hdr_ok;
  logic want_slip;
  logic slip_limit;

  // A valid sync header has exactly one bit set (01 or 10).
  assign hdr_ok     = serdes_rx_hdr[0] ^ serdes_rx_hdr[1];
  assign slip_limit = SLIP_CAPPED && (slip_cnt == SLIP_LAST);

  always_comb begin
    want_slip = 1'b0;
    if (serdes_rx_hdr_valid && !hdr_ok) begin
      if (state == HUNT) want_slip = 1'b1;
      if (state == LOCKED && inv_cnt == INV_LAST) want_slip = 1'b1;
    end
  end

  assign rx_slip_count = slip_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= HUNT;
      sh_cnt              <= '0;
      inv_cnt             <= '0;
      slip_cnt            <= '0;
      timer               <= '0;
      serdes_rx_bitslip   <= 1'b0;
      serdes_rx_reset_req <= 1'b0;
      rx_block_lock       <= 1'b0;
    end else begin
      unique case (state)
        HUNT: begin
          if (serdes_rx_hdr_valid && hdr_ok) begin
            if (sh_cnt == SH_LAST) begin
              state         <= LOCKED;
              rx_block_lock <= 1'b1;
              sh_cnt        <= '0;
              inv_cnt       <= '0;
              slip_cnt      <= '0;
            end else begin
              sh_cnt <= sh_cnt + SW'(1);
            end
          end
        end
        LOCKED: begin
          if (serdes_rx_hdr_valid) begin
            if (sh_cnt == SH_LAST) begin
              sh_cnt  <= '0;
              inv_cnt <= '0;
            end else begin
              sh_cnt <= sh_cnt + SW'(1);
              if (!hdr_ok) inv_cnt <= inv_cnt + IW'(1);
            end
          end
        end
        SLIP: begin
          if (timer == '0) begin
            serdes_rx_bitslip <= 1'b0;
            if (BITSLIP_LOW_CYCLES == 0) begin
              state <= HUNT;
            end else begin
              state <= SETTLE;
              timer <= LOW_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        SETTLE: begin
          if (timer == '0) state <= HUNT;
          else             timer <= timer - TW'(1);
        end
        RESET_HOLD: begin
          if (timer == '0) begin
            serdes_rx_reset_req <= 1'b0;
            slip_cnt            <= '0;
            state               <= HUNT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= HUNT;
      endcase

      // Slip entry overrides the per-state updates above (also covers the
      // 16th-invalid-on-window-end case, where unlock must win).
      if (want_slip) begin
        sh_cnt        <= '0;
        inv_cnt       <= '0;
        rx_block_lock <= 1'b0;
        if (slip_limit) begin
          state               <= RESET_HOLD;
          serdes_rx_reset_req <= 1'b1;
          timer               <= HOLD_LOAD;
        end else begin
          state             <= SLIP;
          serdes_rx_bitslip <= 1'b1;
          timer             <= HIGH_LOAD;
          if (slip_cnt != 7'd127) slip_cnt <= slip_cnt + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock_ctrl.sv
// Bench for the block-lock sequencer: directed and random header streams checked
// every cycle against an event-schedule reference model.
module tb_eth_phy_10g_rx_block_lock_ctrl;

  localparam int HIGH     = 1;
  localparam int LOW      = 8;
  localparam int LOCK_N   = 64;
  localparam int UNLOCK_N = 16;
  localparam int MAX_S    = 66;
  localparam int HOLD     = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] hdr = 2'b00;
  logic       hdr_valid = 1'b0;
  logic       bitslip;
  logic       reset_req;
  logic       block_lock;
  logic [6:0] slip_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edge index plus scheduled output windows.
  int t = 0;
  bit locked = 0;
  int run = 0, win_n = 0, win_bad = 0, slips = 0;
  int bs_lo = 0, bs_hi = 0, rr_lo = 0, rr_hi = 0;
  int ignore_until = 0, clr_at = -1;
  int bs_seen = 0, rr_seen = 0;

  eth_phy_10g_rx_block_lock_ctrl #(
    .HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(HIGH), .BITSLIP_LOW_CYCLES(LOW),
    .LOCK_VALID_COUNT(LOCK_N), .UNLOCK_INVALID_COUNT(UNLOCK_N),
    .MAX_SLIPS(MAX_S), .RESET_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serdes_rx_hdr(hdr),
    .serdes_rx_hdr_valid(hdr_valid),
    .serdes_rx_bitslip(bitslip),
    .serdes_rx_reset_req(reset_req),
    .rx_block_lock(block_lock),
    .rx_slip_count(slip_count)
  );

  always #5 clk = ~clk;

  function automatic void check(string tag, logic [6:0] obs, logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, t, obs, exp);
    end
  endfunction

  function automatic void start_slip();
    if (slips + 1 == MAX_S) begin
      rr_lo = t; rr_hi = t + HOLD;
      ignore_until = t + HOLD + 1;
      clr_at = t + HOLD;
    end else begin
      if (slips < 127) slips++;
      bs_lo = t; bs_hi = t + HIGH;
      ignore_until = t + HIGH + LOW + 1;
    end
  endfunction

  function automatic void model_edge(logic [1:0] h, logic v, logic r);
    bit good;
    good = (h == 2'b01) || (h == 2'b10);
    if (!r) begin
      locked = 0; run = 0; win_n = 0; win_bad = 0; slips = 0;
      bs_lo = 0; bs_hi = 0; rr_lo = 0; rr_hi = 0;
      ignore_until = 0; clr_at = -1;
      return;
    end
    if (t == clr_at) slips = 0;
    if (v && t >= ignore_until) begin
      if (!locked) begin
        if (good) begin
          run++;
          if (run == LOCK_N) begin
            locked = 1; run = 0; slips = 0; win_n = 0; win_bad = 0;
          end
        end else begin
          run = 0;
          start_slip();
        end
      end else begin
        win_n++;
        if (!good) win_bad++;
        if (win_bad == UNLOCK_N) begin
          locked = 0; win_n = 0; win_bad = 0;
          start_slip();
        end else if (win_n == LOCK_N) begin
          win_n = 0; win_bad = 0;
        end
      end
    end
  endfunction

  task automatic step(input logic [1:0] h, input logic v, input logic r);
    bit exp_bs, exp_rr;
    hdr = h; hdr_valid = v; rst = r;
    @(posedge clk);
    #1;
    t++;
    model_edge(h, v, r);
    exp_bs = (t >= bs_lo) && (t < bs_hi);
    exp_rr = (t >= rr_lo) && (t < rr_hi);
    check("bitslip",    {6'b0, bitslip},    {6'b0, exp_bs});
    check("reset_req",  {6'b0, reset_req},  {6'b0, exp_rr});
    check("block_lock", {6'b0, block_lock}, {6'b0, locked});
    check("slip_count", slip_count, 7'(slips));
    if (bitslip === 1'b1)   bs_seen++;
    if (reset_req === 1'b1) rr_seen++;
  endtask

  function automatic logic [1:0] rand_good();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rand_bad();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic do_reset();
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state and basic lock acquisition.
    do_reset();
    check("reset_lock", {6'b0, block_lock}, 7'd0);
    bs_seen = 0;
    for (int i = 0; i < LOCK_N - 1; i++) step(2'b01, 1'b1, 1'b1);
    check("no_lock_at_63", {6'b0, block_lock}, 7'd0);
    step(2'b01, 1'b1, 1'b1);
    check("lock_at_64", {6'b0, block_lock}, 7'd1);
    check("no_slip_pulse", 7'(bs_seen), 7'd0);

    // Slip from HUNT: 10,10,11 then settle; lock needs a fresh 64.
    do_reset();
    bs_seen = 0;
    step(2'b10, 1'b1, 1'b1);
    step(2'b10, 1'b1, 1'b1);
    step(2'b11, 1'b1, 1'b1);
    check("slip_high", {6'b0, bitslip}, 7'd1);
    for (int i = 0; i < HIGH + LOW; i++) step(2'b11, 1'b1, 1'b1);
    check("one_pulse", 7'(bs_seen), 7'd1);
    check("slip_cnt_1", slip_count, 7'd1);
    for (int i = 0; i < LOCK_N; i++) step(rand_good(), 1'b1, 1'b1);
    check("relock", {6'b0, block_lock}, 7'd1);

    // Locked: 15 invalid in a window holds lock, 16 in the next drops it.
    do_reset();
    for (int i = 0; i < LOCK_N; i++) step(2'b01, 1'b1, 1'b1);
    for (int i = 0; i < LOCK_N; i++)
      step(((i % 4) == 0 && i < 60) ? rand_bad() : rand_good(), 1'b1, 1'b1);
    check("lock_held_15", {6'b0, block_lock}, 7'd1);
    bs_seen = 0;
    for (int i = 0; i < UNLOCK_N; i++) step(2'b11, 1'b1, 1'b1);
    check("unlock_16", {6'b0, block_lock}, 7'd0);
    check("unlock_slip", {6'b0, bitslip}, 7'd1);
    for (int i = 0; i < 20; i++) step(rand_good(), 1'b1, 1'b1);

    // Continuous invalid headers: 65 slips then a reset request.
    do_reset();
    bs_seen = 0; rr_seen = 0;
    for (int i = 0; i < (MAX_S - 1) * (HIGH + LOW + 1) + HOLD + 1; i++)
      step(2'b11, 1'b1, 1'b1);
    check("pulses_65", 7'(bs_seen), 7'd65);
    check("reset_req_32", 7'(rr_seen), 7'd32);
    check("slip_cnt_cleared", slip_count, 7'd0);
    for (int i = 0; i < LOCK_N; i++) step(2'b10, 1'b1, 1'b1);
    check("lock_after_hold", {6'b0, block_lock}, 7'd1);

    // Gapped headers: lock after 64 qualified headers, not 64 cycles.
    do_reset();
    for (int i = 0; i < LOCK_N; i++) step(2'b01, 1'((i % 2) == 0), 1'b1);
    check("gap_no_lock", {6'b0, block_lock}, 7'd0);
    for (int i = LOCK_N; i < 2 * LOCK_N; i++) step(2'b01, 1'((i % 2) == 0), 1'b1);
    check("gap_lock", {6'b0, block_lock}, 7'd1);

    // Reset mid-SLIP.
    do_reset();
    step(2'b11, 1'b1, 1'b1);
    check("mid_slip_high", {6'b0, bitslip}, 7'd1);
    step(2'b11, 1'b1, 1'b0);
    check("rst_slip_bs", {6'b0, bitslip}, 7'd0);
    for (int i = 0; i < LOCK_N; i++) step(2'b01, 1'b1, 1'b1);
    check("lock_after_rst", {6'b0, block_lock}, 7'd1);

    // Reset mid-RESET_HOLD, bounded search for the hold window.
    do_reset();
    for (int i = 0; i < 900 && !(rr_hi != 0 && t >= rr_lo + 5); i++)
      step(2'b11, 1'b1, 1'b1);
    check("hold_reached", {6'b0, reset_req}, 7'd1);
    step(2'b11, 1'b1, 1'b0);
    check("rst_hold_rr", {6'b0, reset_req}, 7'd0);
    for (int i = 0; i < LOCK_N + 4; i++) step(2'b10, 1'b1, 1'b1);

    // Random traffic at several error rates with random gaps.
    for (int seg = 0; seg < 4; seg++) begin
      int pbad;
      pbad = (seg == 0) ? 0 : (seg == 1) ? 1 : (seg == 2) ? 5 : 30;
      for (int i = 0; i < 1500; i++) begin
        logic v;
        logic [1:0] h;
        v = ($urandom_range(0, 3) != 0);
        h = ($urandom_range(0, 99) < pbad) ? rand_bad() : rand_good();
        step(h, v, ($urandom_range(0, 999) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_rx_block_lock_ctrl.md
Name: eth_phy_10g_rx_block_lock_ctrl

Overview:
- Block-lock and bitslip sequencer for the 10GBASE-R receive path, after the SERDES gearbox and ahead of descrambling/decoding.
- Monitors 2-bit sync headers, drives the SERDES bitslip handshake until 66-bit alignment is found, and reports rx_block_lock.
- Requests a SERDES reset when alignment cannot be found after a bounded number of slips.

Parameters:
- HDR_WIDTH, 2, sync header width; fixed at 2.
- BITSLIP_HIGH_CYCLES, 1, cycles serdes_rx_bitslip is held high per slip; must be >= 1.
- BITSLIP_LOW_CYCLES, 8, settle cycles after a slip during which headers are ignored; must be >= 0.
- LOCK_VALID_COUNT, 64, consecutive valid headers needed to declare lock.
- UNLOCK_INVALID_COUNT, 16, invalid headers within one LOCK_VALID_COUNT window that drop lock.
- MAX_SLIPS, 66, slips without achieving lock before a SERDES reset is requested.
- RESET_HOLD_CYCLES, 32, cycles serdes_rx_reset_req is held high.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-low reset.
- serdes_rx_hdr, input, HDR_WIDTH, sync header of the current block.
- serdes_rx_hdr_valid, input, 1, qualifies serdes_rx_hdr for one cycle (gearbox gaps).
- serdes_rx_bitslip, output, 1, bitslip request to the SERDES.
- serdes_rx_reset_req, output, 1, SERDES/gearbox reset request.
- rx_block_lock, output, 1, block alignment achieved.
- rx_slip_count, output, 7, slips since the last lock or reset; saturates at 127.

Behaviour:
- Header validity: valid when serdes_rx_hdr is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid. Headers are sampled only when serdes_rx_hdr_valid=1.
- Reset (rst=0 at a clk edge):
  - All outputs 0; all counters 0; state HUNT.
  - Takes effect from any state, including mid-slip or mid-reset-hold. Outputs deassert on the next edge.
- Counters:
  - sh_cnt counts sampled headers in the current window.
  - inv_cnt counts invalid headers in the current window.
  - slip_cnt counts slips.
- HUNT:
  - Valid header: sh_cnt++. When sh_cnt reaches LOCK_VALID_COUNT, go to LOCKED, set rx_block_lock=1 on the next edge, and clear sh_cnt, inv_cnt and slip_cnt.
  - Invalid header: go to SLIP. If slip_cnt+1 == MAX_SLIPS, go to RESET_HOLD instead.
- SLIP:
  - serdes_rx_bitslip=1 for exactly BITSLIP_HIGH_CYCLES, starting the cycle after the invalid header is sampled.
  - slip_cnt increments once per slip; rx_slip_count saturates at 127.
  - Clear sh_cnt and inv_cnt, then go to SETTLE.
- SETTLE:
  - serdes_rx_bitslip=0 for BITSLIP_LOW_CYCLES cycles; headers are ignored.
  - If BITSLIP_LOW_CYCLES=0, return to HUNT immediately.
- LOCKED:
  - Every sampled header increments sh_cnt; each invalid header also increments inv_cnt.
  - When inv_cnt reaches UNLOCK_INVALID_COUNT, set rx_block_lock=0 on the next edge and go to SLIP.
  - When sh_cnt reaches LOCK_VALID_COUNT and inv_cnt < UNLOCK_INVALID_COUNT, clear both counters and stay LOCKED.
  - If the 64th header of a window is also the 16th invalid header, the unlock wins.
- RESET_HOLD:
  - serdes_rx_reset_req=1 for RESET_HOLD_CYCLES; rx_block_lock=0; bitslip=0.
  - Then clear slip_cnt and go to HUNT.
- Bitslip pulses are never back-to-back without the full SETTLE interval between them.
- serdes_rx_hdr_valid=0 cycles freeze the counters but do not pause the SLIP/SETTLE/RESET_HOLD timers.

Test Plan:
- Reset, then 64 consecutive 2'b01 headers with hdr_valid=1 every cycle -> rx_block_lock rises the cycle after the 64th header; no bitslip pulse; rx_slip_count=0.
- HUNT, header sequence 10,10,11 -> serdes_rx_bitslip high for exactly 1 cycle, then 8 cycles low with headers ignored; rx_slip_count=1; lock requires a fresh 64 valid headers.
- Locked, 15 invalid headers spread across a 64-header window -> lock held and counters cleared at the window end. Then 16 invalid headers within the next window -> rx_block_lock falls the cycle after the 16th, followed by a bitslip pulse.
- Continuous 2'b11 headers from reset -> 65 bitslip pulses, then serdes_rx_reset_req high for 32 cycles, then HUNT with rx_slip_count=0.
- hdr_valid toggled 1/0 alternately with valid headers -> lock after 64 qualified headers (about 128 cycles), not 64 cycles.
- rst driven low mid-SLIP and mid-RESET_HOLD -> bitslip, reset_req and rx_block_lock are all 0 on the next edge; the block restarts cleanly in HUNT.
